image_parallel_processing_mem_arbiter: RTL and testbench
========================================================

IMAGE_PARALLEL_PROCESSING_MEM_ARBITER -- requirements
Module: image_parallel_processing_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 17, word-address width; DATA_W, default 32, data width; DEPTH, default 120000, number of valid words.
REQ-002 Port clk, input, 1, single clock for all logic.
REQ-003 Port reset_n, input, 1, asynchronous active-low reset.
REQ-004 Ports m0_address/m1_address, input, ADDR_W, master word address.
REQ-005 Ports m0_byteenable/m1_byteenable, input, DATA_W/8, byte lanes.
REQ-006 Ports m0_read/m1_read and m0_write/m1_write, input, 1, access requests.
REQ-007 Ports m0_writedata/m1_writedata, input, DATA_W, write data.
REQ-008 Ports m0_readdata/m1_readdata, output, DATA_W, read return.
REQ-009 Ports m0_readdatavalid/m1_readdatavalid, output, 1, read-return strobe.
REQ-010 Ports m0_waitrequest/m1_waitrequest, output, 1, request stalled this cycle.
REQ-011 Ports ram_address (ADDR_W), ram_byteenable (DATA_W/8), ram_writedata (DATA_W), ram_chipselect, ram_write and ram_clken (1 bit each), output, drive the single-port RAM.
REQ-012 Port ram_readdata, input, DATA_W, RAM output, valid one cycle after the address is presented.
REQ-013 Port err_count, output, 16, saturating count of out-of-range accesses.

Function
REQ-014 A master SHALL be requesting when its read or write is high; read and write both high SHALL be treated as a write.
REQ-015 Exactly one requesting master SHALL be granted per cycle; the grant is combinational from the current requests and the registered last_grant pointer.
REQ-016 With one master requesting, that master SHALL be granted.
REQ-017 With both requesting, the master not in last_grant SHALL be granted (round-robin); last_grant updates on every grant.
REQ-018 waitrequest SHALL equal request AND NOT grant, per master; a granted access completes in that cycle.
REQ-019 ram_address, ram_byteenable, ram_writedata and ram_write SHALL pass the granted master's signals combinationally; ram_chipselect SHALL be high only for a granted in-range access.
REQ-020 ram_write SHALL be low when no master is granted; ram_clken SHALL be constant 1.
REQ-021 A granted read SHALL load a one-entry pending register {valid, owner, oor}.
REQ-022 The owner's readdatavalid SHALL pulse exactly one cycle after the grant, and its readdata SHALL equal ram_readdata, or 0 if oor is set.
REQ-023 The non-owner's readdatavalid SHALL be 0, and its readdata SHALL hold 0.
REQ-024 Back-to-back reads SHALL sustain one read per cycle, with returns in grant order.
REQ-025 An access with address >= DEPTH SHALL still be granted, SHALL NOT assert ram_chipselect, and SHALL increment err_count, which saturates at 0xFFFF.
REQ-026 Writes SHALL produce no readdatavalid.

Reset
REQ-027 While reset_n is low: both waitrequest = 1, both readdatavalid = 0, both readdata = 0, ram_chipselect = 0, ram_write = 0, err_count = 0, pending.valid = 0, last_grant = 1 (so m0 wins the first tie).
REQ-028 Reset asserted with a read pending SHALL discard that read; no readdatavalid SHALL follow deassertion.

Structure
REQ-029 A shared package SHALL hold ADDR_W, DATA_W and DEPTH defaults and the master-index type.
REQ-030 One sub-module, image_parallel_processing_rr_arbiter2, SHALL implement the two-requester round-robin grant and last_grant register; the top level SHALL own the datapath mux, pending register and err_count.

Verification
REQ-031 m0 writes 0xA5A5A5A5 to address 0x00010 with byteenable 0xF, then reads it -> m0_readdatavalid rises one cycle after the read grant with m0_readdata = 0xA5A5A5A5.
REQ-032 m0 and m1 both read continuously for 6 cycles after reset -> grants alternate m0, m1, m0, ...; each master sees waitrequest = 1 on alternate cycles, and each master receives 3 returns.
REQ-033 m1 writes 0x11223344 to address 5 with byteenable 0x3 over existing 0xFFFFFFFF -> a subsequent read returns 0xFFFF3344.
REQ-034 m0 reads address 120000 -> ram_chipselect = 0, m0_readdata = 0 with readdatavalid one cycle later, err_count = 1; 70000 such accesses leave err_count = 0xFFFF.
REQ-035 m1 read granted, then reset_n pulled low for 1 cycle on the following edge -> no m1_readdatavalid afterwards and all outputs at their REQ-027 values.

Source files
------------

// File: rtl/image_parallel_processing_mem_arbiter_pkg.sv
// rtl/image_parallel_processing_mem_arbiter_pkg.sv - shared widths, depth and master index type
package image_parallel_processing_mem_arbiter_pkg;
   localparam int ADDR_W_DEF = 17;
   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 120000;

   typedef enum logic {MST_M0 = 1'b0, MST_M1 = 1'b1} master_idx_t;

   typedef struct packed {
      logic        valid;
      master_idx_t owner;
      logic        oor;
   } pending_t;
endpackage

// File: rtl/image_parallel_processing_mem_arbiter_if.sv
// rtl/image_parallel_processing_mem_arbiter_if.sv - one master's memory-mapped access port
interface image_parallel_processing_mem_arbiter_if
   import image_parallel_processing_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;
   logic                waitrequest;

   modport master (
      output address, byteenable, read, write, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/image_parallel_processing_rr_arbiter2.sv
// rtl/image_parallel_processing_rr_arbiter2.sv - two-requester round-robin grant with last_grant pointer
module image_parallel_processing_rr_arbiter2
   import image_parallel_processing_mem_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  req,
   output logic [1:0]  grant,
   output master_idx_t grant_idx
);
   master_idx_t last_grant;

   always_comb begin
      grant_idx = MST_M0;
      if (req == 2'b11) begin
         grant_idx = (last_grant == MST_M0) ? MST_M1 : MST_M0;
      end else if (req[1]) begin
         grant_idx = MST_M1;
      end
      grant = 2'b00;
      if (req != 2'b00) begin
         grant = (grant_idx == MST_M1) ? 2'b10 : 2'b01;
      end
   end

   // Reset to m1 so that m0 wins the first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= MST_M1;
      end else if (req != 2'b00) begin
         last_grant <= grant_idx;
      end
   end
endmodule

// File: rtl/image_parallel_processing_mem_arbiter.sv
// rtl/image_parallel_processing_mem_arbiter.sv - two-master arbiter onto a single-port RAM
module image_parallel_processing_mem_arbiter
   import image_parallel_processing_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
)(
   input  logic                clk,
   input  logic                reset_n,
   image_parallel_processing_mem_arbiter_if.slave m0,
   image_parallel_processing_mem_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic [DATA_W-1:0]   ram_writedata,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic                ram_clken,
   input  logic [DATA_W-1:0]   ram_readdata,
   output logic [15:0]         err_count
);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   logic [1:0]  req;
   logic [1:0]  grant;
   master_idx_t grant_idx;
   logic        any_grant;
   logic        sel_write;
   logic        in_range;
   pending_t    pend;

   // Requests are masked in reset so nothing reaches the RAM or the pointer.
   assign req[0] = reset_n & (m0.read | m0.write);
   assign req[1] = reset_n & (m1.read | m1.write);

   image_parallel_processing_rr_arbiter2 u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign any_grant      = |grant;
   assign ram_address    = grant[1] ? m1.address    : m0.address;
   assign ram_byteenable = grant[1] ? m1.byteenable : m0.byteenable;
   assign ram_writedata  = grant[1] ? m1.writedata  : m0.writedata;
   assign sel_write      = grant[1] ? m1.write      : m0.write;
   assign in_range       = {1'b0, ram_address} < DEPTH_L;

   assign ram_write      = any_grant & sel_write;
   assign ram_chipselect = any_grant & in_range;
   assign ram_clken      = 1'b1;

   assign m0.waitrequest = ~reset_n | (req[0] & ~grant[0]);
   assign m1.waitrequest = ~reset_n | (req[1] & ~grant[1]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend <= '{valid: 1'b0, owner: MST_M0, oor: 1'b0};
      end else begin
         pend.valid <= any_grant & ~sel_write;
         pend.owner <= grant_idx;
         pend.oor   <= ~in_range;
      end
   end

   assign m0.readdatavalid = pend.valid & (pend.owner == MST_M0);
   assign m1.readdatavalid = pend.valid & (pend.owner == MST_M1);
   assign m0.readdata = (m0.readdatavalid && !pend.oor) ? ram_readdata : '0;
   assign m1.readdata = (m1.readdatavalid && !pend.oor) ? ram_readdata : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count <= 16'h0000;
      end else if (any_grant && !in_range && err_count != 16'hFFFF) begin
         err_count <= err_count + 16'h0001;
      end
   end
endmodule

// File: tb/tb_image_parallel_processing_mem_arbiter.sv
// tb/tb_image_parallel_processing_mem_arbiter.sv - scoreboard bench with random and directed accesses
module tb_image_parallel_processing_mem_arbiter;
   localparam int DEPTH = 120000;

   typedef struct packed {
      bit          rd;
      bit          wr;
      logic [16:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } acc_t;

   typedef struct {
      logic [31:0] data;
      int unsigned stamp;
   } ret_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [16:0] ram_address;
   logic [3:0]  ram_byteenable;
   logic [31:0] ram_writedata;
   logic        ram_chipselect;
   logic        ram_write;
   logic        ram_clken;
   logic [31:0] ram_readdata = '0;
   logic [15:0] err_count;

   image_parallel_processing_mem_arbiter_if m0_if ();
   image_parallel_processing_mem_arbiter_if m1_if ();

   image_parallel_processing_mem_arbiter dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .m0             (m0_if),
      .m1             (m1_if),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_writedata  (ram_writedata),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_clken      (ram_clken),
      .ram_readdata   (ram_readdata),
      .err_count      (err_count)
   );

   always #5 clk = ~clk;

   bit [31:0] ram_mem [0:131071];
   bit [31:0] exp_mem [0:131071];

   // Single-port RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (ram_chipselect && ram_clken) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         end else begin
            ram_readdata <= ram_mem[ram_address];
         end
      end
   end

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   ret_t q0[$];
   ret_t q1[$];
   int rdv_cnt0 = 0;
   int rdv_cnt1 = 0;
   int last_served = 1;
   int exp_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit in_range(input logic [16:0] a);
      return int'(a) < DEPTH;
   endfunction

   ret_t e0, e1;
   always @(negedge clk) begin
      if (reset_n) begin
         if (q0.size() != 0 && q0[0].stamp < cyc) begin
            chk("m0_missing_return", 32'(0), 32'(1));
            void'(q0.pop_front());
         end
         if (q1.size() != 0 && q1[0].stamp < cyc) begin
            chk("m1_missing_return", 32'(0), 32'(1));
            void'(q1.pop_front());
         end
         if (m0_if.readdatavalid) begin
            rdv_cnt0++;
            if (q0.size() == 0) chk("m0_unexpected_rdv", 32'(1), 32'(0));
            else begin
               e0 = q0.pop_front();
               chk("m0_rdv_timing", cyc, e0.stamp);
               chk("m0_readdata", m0_if.readdata, e0.data);
            end
         end else begin
            chk("m0_readdata_idle", m0_if.readdata, 32'(0));
         end
         if (m1_if.readdatavalid) begin
            rdv_cnt1++;
            if (q1.size() == 0) chk("m1_unexpected_rdv", 32'(1), 32'(0));
            else begin
               e1 = q1.pop_front();
               chk("m1_rdv_timing", cyc, e1.stamp);
               chk("m1_readdata", m1_if.readdata, e1.data);
            end
         end else begin
            chk("m1_readdata_idle", m1_if.readdata, 32'(0));
         end
      end
   end

   task automatic apply(input acc_t a0, input acc_t a1);
      m0_if.read = a0.rd; m0_if.write = a0.wr; m0_if.address = a0.addr;
      m0_if.byteenable = a0.be; m0_if.writedata = a0.data;
      m1_if.read = a1.rd; m1_if.write = a1.wr; m1_if.address = a1.addr;
      m1_if.byteenable = a1.be; m1_if.writedata = a1.data;
   endtask

   // Drive one cycle of requests, predict the outcome from the access rules, advance.
   task automatic step(input acc_t a0, input acc_t a1);
      acc_t a[2];
      bit   req[2];
      int   g;
      ret_t r;
      a[0] = a0; a[1] = a1;
      apply(a0, a1);
      req[0] = a0.rd | a0.wr;
      req[1] = a1.rd | a1.wr;
      g = -1;
      if (req[0] && req[1]) g = (last_served == 0) ? 1 : 0;
      else if (req[0]) g = 0;
      else if (req[1]) g = 1;
      @(negedge clk);
      chk("err_count", 32'(err_count), 32'(exp_err));
      chk("m0_waitrequest", 32'(m0_if.waitrequest), 32'(req[0] && g != 0));
      chk("m1_waitrequest", 32'(m1_if.waitrequest), 32'(req[1] && g != 1));
      chk("ram_chipselect", 32'(ram_chipselect), 32'(g >= 0 && in_range(a[g >= 0 ? g : 0].addr)));
      chk("ram_write", 32'(ram_write), 32'(g >= 0 && a[g >= 0 ? g : 0].wr));
      if (g >= 0) begin
         last_served = g;
         if (!in_range(a[g].addr)) begin
            if (exp_err < 65535) exp_err++;
         end else if (a[g].wr) begin
            for (int b = 0; b < 4; b++)
               if (a[g].be[b]) exp_mem[a[g].addr][8*b +: 8] = a[g].data[8*b +: 8];
         end
         if (!a[g].wr) begin
            r.data  = in_range(a[g].addr) ? exp_mem[a[g].addr] : 32'h0;
            r.stamp = cyc + 1;
            if (g == 0) q0.push_back(r);
            else        q1.push_back(r);
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic acc_t mk(input bit rd, input bit wr, input int addr,
                               input logic [3:0] be, input logic [31:0] data);
      acc_t a;
      a.rd = rd; a.wr = wr; a.addr = 17'(addr); a.be = be; a.data = data;
      return a;
   endfunction

   function automatic acc_t rand_acc();
      acc_t a;
      int   k;
      a.rd = ($urandom_range(0, 2) != 0);
      a.wr = ($urandom_range(0, 3) == 0);
      k = $urandom_range(0, 11);
      case (k)
         0:       a.addr = 17'(DEPTH);
         1:       a.addr = 17'(DEPTH - 1);
         2:       a.addr = 17'h1FFFF;
         default: a.addr = 17'($urandom_range(0, 31));
      endcase
      a.be   = 4'($urandom_range(0, 15));
      a.data = $urandom;
      return a;
   endfunction

   task automatic check_reset_state(input string tag);
      chk({tag, "_m0_waitrequest"}, 32'(m0_if.waitrequest), 32'(1));
      chk({tag, "_m1_waitrequest"}, 32'(m1_if.waitrequest), 32'(1));
      chk({tag, "_m0_rdv"}, 32'(m0_if.readdatavalid), 32'(0));
      chk({tag, "_m1_rdv"}, 32'(m1_if.readdatavalid), 32'(0));
      chk({tag, "_m0_readdata"}, m0_if.readdata, 32'(0));
      chk({tag, "_m1_readdata"}, m1_if.readdata, 32'(0));
      chk({tag, "_chipselect"}, 32'(ram_chipselect), 32'(0));
      chk({tag, "_ram_write"}, 32'(ram_write), 32'(0));
      chk({tag, "_err_count"}, 32'(err_count), 32'(0));
      chk({tag, "_clken"}, 32'(ram_clken), 32'(1));
   endtask

   acc_t idle;
   int   c0, c1;

   initial begin
      idle = '0;
      apply(mk(1, 0, 3, 4'hF, 0), mk(0, 1, 4, 4'hF, 32'h1));
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Both masters reading back-to-back: strict alternation starting with m0.
      c0 = rdv_cnt0; c1 = rdv_cnt1;
      for (int i = 0; i < 6; i++) step(mk(1, 0, i, 4'hF, 0), mk(1, 0, 8 + i, 4'hF, 0));
      step(idle, idle);
      chk("alt_m0_returns", 32'(rdv_cnt0 - c0), 32'(3));
      chk("alt_m1_returns", 32'(rdv_cnt1 - c1), 32'(3));

      step(mk(0, 1, 'h10, 4'hF, 32'hA5A5A5A5), idle);
      step(mk(1, 0, 'h10, 4'hF, 0), idle);
      step(idle, mk(0, 1, 5, 4'hF, 32'hFFFFFFFF));
      step(idle, mk(0, 1, 5, 4'h3, 32'h11223344));
      step(idle, mk(1, 0, 5, 4'hF, 0));
      step(idle, idle);
      chk("partial_write_mem", exp_mem[5], 32'hFFFF3344);

      for (int i = 0; i < 1500; i++) step(rand_acc(), rand_acc());
      step(idle, idle);

      // Fresh reset, then out-of-range reads until err_count saturates.
      reset_n = 1'b0; q0.delete(); q1.delete();
      @(posedge clk); #1;
      reset_n = 1'b1; last_served = 1; exp_err = 0;
      step(mk(1, 0, DEPTH, 4'hF, 0), idle);
      step(idle, idle);
      chk("err_one", 32'(err_count), 32'(1));
      for (int i = 0; i < 69999; i++) step(mk(1, 0, DEPTH, 4'hF, 0), idle);
      step(idle, idle);
      chk("err_saturated", 32'(err_count), 32'h0000FFFF);

      // m1 read granted, reset lands on the next edge: its return must vanish.
      step(idle, mk(1, 0, 5, 4'hF, 0));
      reset_n = 1'b0;
      q0.delete(); q1.delete();
      apply(mk(1, 0, 3, 4'hF, 0), mk(0, 1, 4, 4'hF, 32'h1));
      @(negedge clk);
      check_reset_state("midreset");
      @(posedge clk); #1;
      reset_n = 1'b1; last_served = 1; exp_err = 0;
      c1 = rdv_cnt1;
      step(idle, idle);
      step(idle, idle);
      chk("discarded_read", 32'(rdv_cnt1 - c1), 32'(0));
      step(mk(1, 0, 7, 4'hF, 0), mk(1, 0, 9, 4'hF, 0));
      step(mk(1, 0, 7, 4'hF, 0), mk(1, 0, 9, 4'hF, 0));
      step(idle, idle);
      step(idle, idle);
      chk("q0_drained", 32'(q0.size()), 32'(0));
      chk("q1_drained", 32'(q1.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
